dcsk_tx_core: RTL and testbench
===============================

DCSK_TX_CORE -- requirements
Module: dcsk_tx_core

Interface
REQ-001 Parameter MSG_W, default 32: message length in bits per transfer, legal 1..64.
REQ-002 Parameter SF_W, default 5: spreading-factor field width; chips per half-frame SF is legal 1..2^SF_W-1.
REQ-003 Parameter LFSR_W, default 16: chaos-generator state width.
REQ-004 Parameter POLY, default 16'hB400: Galois feedback mask, LFSR_W bits.
REQ-005 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-006 i_arst_n  in  1  reset, synchronous, active-low.
REQ-007 i_seed  in  LFSR_W  chaos seed.
REQ-008 i_load_seed  in  1  seed load strobe.
REQ-009 i_sf  in  SF_W  chips per half-frame, sampled at message acceptance.
REQ-010 i_msb_first  in  1  bit order (1 = MSB first, 0 = LSB first), sampled at acceptance.
REQ-011 i_msg  in  MSG_W  message word.
REQ-012 i_msg_valid  in  1  message offered.
REQ-013 o_msg_ready  out  1  pending slot free; transfer on i_msg_valid & o_msg_ready.
REQ-014 o_tx  out  1  modulated chip, registered.
REQ-015 o_tx_valid  out  1  o_tx carries a chip this cycle.
REQ-016 o_frame_half  out  1  0 = reference half, 1 = data half of current chip.
REQ-017 o_bit_idx  out  $clog2(MSG_W+1)  index (0-based, transmission order) of bit being sent.
REQ-018 o_is_sending  out  1  FSM not in IDLE.

Function
REQ-019 Chaos source: chip = lfsr[0]; advance = (lfsr>>1) ^ (lfsr[0] ? POLY : 0); advance only when a reference chip is produced.
REQ-020 i_load_seed honoured only in IDLE; ignored otherwise; seed 0 loads 1 (LFSR never all-zero).
REQ-021 Pending slot: one MSG_W register plus captured SF/order; o_msg_ready = slot empty; acceptance fills slot, promotion to active empties it.
REQ-022 i_sf = 0 at acceptance treated as SF = 1.
REQ-023 FSM states IDLE, REF, DATA; IDLE->REF when slot full (promote in same edge); REF->DATA after SF reference chips; DATA->REF after SF data chips if bits remain; after last bit DATA->REF with promotion if slot full, else DATA->IDLE.
REQ-024 REF: each cycle o_tx = chaos chip, chip stored in reference buffer (depth 2^SF_W-1) at chip index, o_frame_half=0.
REQ-025 DATA: o_tx = buffer[chip index] XNOR msg bit (bit 1 -> reference repeated, bit 0 -> inverted), o_frame_half=1.
REQ-026 Latency: handshake on edge k into empty IDLE core -> first reference chip on o_tx with o_tx_valid=1 after edge k+2.
REQ-027 Frame length exactly 2*SF chips per bit; message exactly 2*SF*MSG_W consecutive valid chips.
REQ-028 Back-to-back: message in slot at final data chip starts next REF chip on the following cycle; no o_tx_valid gap.
REQ-029 Chip counter wraps 0..SF-1 per half; bit counter 0..MSG_W-1, clears on promotion.
REQ-030 Acceptance while sending allowed when slot empty; active SF/order/message never change mid-message.
REQ-031 o_tx_valid = 0 and o_tx = 0 in IDLE.

Reset
REQ-032 On reset (sampled low at an edge): state IDLE, slot empty, o_msg_ready=1 from the following cycle, lfsr = 1, o_tx=0, o_tx_valid=0, o_frame_half=0, o_bit_idx=0, o_is_sending=0, buffer contents don't-care.
REQ-033 Reset mid-message aborts immediately; no further valid chips; pending message discarded.
REQ-034 Handshake coincident with reset asserted is discarded.

Verification
REQ-035 Seed 16'h0001, SF=4, MSG_W=8, msg 8'hA5 MSB-first -> 64 valid chips; each data half equals reference half for bits 1, inverted for bits 0; bit index 0..7.
REQ-036 Load seed 0 in IDLE -> LFSR chip sequence identical to seed 1.
REQ-037 Two messages 8'hFF then 8'h00 offered back-to-back, SF=3 -> 96 contiguous valid chips, o_msg_ready low only while slot full.
REQ-038 i_sf changed 4->7 and i_load_seed pulsed during first message -> first message keeps SF=4 and LFSR sequence; second uses SF=7.
REQ-039 Reset asserted at chip 10 of a message -> o_tx_valid=0 next cycle, outputs at reset values, o_msg_ready=1.
REQ-040 i_sf=0, LSB-first, msg 8'h01 -> 2-chip frames, first bit sent is 1 (data chip equals reference chip).

Source files
------------

// File: rtl/dcsk_tx_core.sv
// DCSK transmitter: LFSR chaos source, one-deep message slot, REF/DATA frame FSM.
// Each message bit is sent as SF reference chips followed by SF data chips.
module dcsk_tx_core #(
    parameter int                MSG_W  = 32,
    parameter int                SF_W   = 5,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] POLY   = 16'hB400
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic [LFSR_W-1:0]          i_seed,
    input  logic                       i_load_seed,
    input  logic [SF_W-1:0]            i_sf,
    input  logic                       i_msb_first,
    input  logic [MSG_W-1:0]           i_msg,
    input  logic                       i_msg_valid,
    output logic                       o_msg_ready,
    output logic                       o_tx,
    output logic                       o_tx_valid,
    output logic                       o_frame_half,
    output logic [$clog2(MSG_W+1)-1:0] o_bit_idx,
    output logic                       o_is_sending
);
    localparam int BI_W  = $clog2(MSG_W + 1);
    localparam int DEPTH = (1 << SF_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REF,
        ST_DATA
    } state_t;

    state_t            state_reg, state_next;
    logic [SF_W-1:0]   chip_reg, chip_next;
    logic [BI_W-1:0]   bit_reg, bit_next;
    logic [LFSR_W-1:0] lfsr_reg, lfsr_adv;

    logic              slot_full_reg;
    logic [MSG_W-1:0]  slot_msg_reg;
    logic [MSG_W-1:0]  slot_msg_rev;
    logic [SF_W-1:0]   slot_sf_reg;
    logic              slot_msb_reg;

    // Active message is stored already in transmission order, so bit_reg indexes it directly.
    logic [MSG_W-1:0]  act_msg_reg;
    logic [SF_W-1:0]   act_sf_reg;

    logic              tx_reg;
    logic              tx_valid_reg;
    logic              half_reg;
    logic [BI_W-1:0]   bit_idx_out_reg;

    logic              ref_buf [0:DEPTH-1];

    logic              accept;
    logic              promote;
    logic              last_chip;
    logic              last_bit;
    logic              cur_bit;

    genvar gi;
    generate
        for (gi = 0; gi < MSG_W; gi++) begin : g_rev
            assign slot_msg_rev[gi] = slot_msg_reg[MSG_W-1-gi];
        end
    endgenerate

    assign accept    = i_msg_valid & ~slot_full_reg;
    assign last_chip = (chip_reg == act_sf_reg - SF_W'(1));
    assign last_bit  = (bit_reg == BI_W'(MSG_W - 1));
    assign lfsr_adv  = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? POLY : '0);

    always_comb begin
        cur_bit = 1'b0;
        for (int i = 0; i < MSG_W; i++) begin
            if (bit_reg == BI_W'(i)) begin
                cur_bit = act_msg_reg[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        chip_next  = chip_reg;
        bit_next   = bit_reg;
        promote    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (slot_full_reg) begin
                    promote    = 1'b1;
                    state_next = ST_REF;
                    chip_next  = '0;
                    bit_next   = '0;
                end
            end
            ST_REF: begin
                if (last_chip) begin
                    chip_next  = '0;
                    state_next = ST_DATA;
                end else begin
                    chip_next = chip_reg + SF_W'(1);
                end
            end
            ST_DATA: begin
                if (last_chip) begin
                    chip_next = '0;
                    if (!last_bit) begin
                        bit_next   = bit_reg + BI_W'(1);
                        state_next = ST_REF;
                    end else if (slot_full_reg) begin
                        // Chain straight into the next message without an idle cycle.
                        promote    = 1'b1;
                        bit_next   = '0;
                        state_next = ST_REF;
                    end else begin
                        bit_next   = '0;
                        state_next = ST_IDLE;
                    end
                end else begin
                    chip_next = chip_reg + SF_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                chip_next  = '0;
                bit_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            state_reg       <= ST_IDLE;
            chip_reg        <= '0;
            bit_reg         <= '0;
            lfsr_reg        <= LFSR_W'(1);
            slot_full_reg   <= 1'b0;
            tx_reg          <= 1'b0;
            tx_valid_reg    <= 1'b0;
            half_reg        <= 1'b0;
            bit_idx_out_reg <= '0;
        end else begin
            state_reg <= state_next;
            chip_reg  <= chip_next;
            bit_reg   <= bit_next;

            if (accept) begin
                slot_full_reg <= 1'b1;
            end else if (promote) begin
                slot_full_reg <= 1'b0;
            end

            if (state_reg == ST_IDLE && i_load_seed) begin
                lfsr_reg <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
            end else if (state_reg == ST_REF) begin
                lfsr_reg <= lfsr_adv;
            end

            case (state_reg)
                ST_REF: begin
                    tx_reg          <= lfsr_reg[0];
                    tx_valid_reg    <= 1'b1;
                    half_reg        <= 1'b0;
                    bit_idx_out_reg <= bit_reg;
                end
                ST_DATA: begin
                    tx_reg          <= ref_buf[chip_reg] ~^ cur_bit;
                    tx_valid_reg    <= 1'b1;
                    half_reg        <= 1'b1;
                    bit_idx_out_reg <= bit_reg;
                end
                default: begin
                    tx_reg          <= 1'b0;
                    tx_valid_reg    <= 1'b0;
                    half_reg        <= 1'b0;
                    bit_idx_out_reg <= '0;
                end
            endcase
        end
    end

    // Payload registers need no reset: they are only consumed behind slot_full_reg / FSM state.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            slot_msg_reg <= i_msg;
            slot_sf_reg  <= (i_sf == '0) ? SF_W'(1) : i_sf;
            slot_msb_reg <= i_msb_first;
        end
        if (promote) begin
            act_msg_reg <= slot_msb_reg ? slot_msg_rev : slot_msg_reg;
            act_sf_reg  <= slot_sf_reg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (state_reg == ST_REF) begin
            ref_buf[chip_reg] <= lfsr_reg[0];
        end
    end

    assign o_msg_ready  = ~slot_full_reg;
    assign o_tx         = tx_reg;
    assign o_tx_valid   = tx_valid_reg;
    assign o_frame_half = half_reg;
    assign o_bit_idx    = bit_idx_out_reg;
    assign o_is_sending = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dcsk_tx_core.sv
// Scoreboard bench for dcsk_tx_core: expected chips queued at handshake, a monitor pops per valid chip.
module tb_dcsk_tx_core;
    localparam int MSG_W  = 8;
    localparam int SF_W   = 5;
    localparam int LFSR_W = 16;
    localparam int BI_W   = $clog2(MSG_W + 1);

    logic              i_clk;
    logic              i_arst_n;
    logic [LFSR_W-1:0] i_seed;
    logic              i_load_seed;
    logic [SF_W-1:0]   i_sf;
    logic              i_msb_first;
    logic [MSG_W-1:0]  i_msg;
    logic              i_msg_valid;
    logic              o_msg_ready;
    logic              o_tx;
    logic              o_tx_valid;
    logic              o_frame_half;
    logic [BI_W-1:0]   o_bit_idx;
    logic              o_is_sending;

    dcsk_tx_core #(
        .MSG_W (MSG_W),
        .SF_W  (SF_W),
        .LFSR_W(LFSR_W),
        .POLY  (16'hB400)
    ) dut (
        .i_clk       (i_clk),
        .i_arst_n    (i_arst_n),
        .i_seed      (i_seed),
        .i_load_seed (i_load_seed),
        .i_sf        (i_sf),
        .i_msb_first (i_msb_first),
        .i_msg       (i_msg),
        .i_msg_valid (i_msg_valid),
        .o_msg_ready (o_msg_ready),
        .o_tx        (o_tx),
        .o_tx_valid  (o_tx_valid),
        .o_frame_half(o_frame_half),
        .o_bit_idx   (o_bit_idx),
        .o_is_sending(o_is_sending)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic            tx;
        logic            half;
        logic [BI_W-1:0] bidx;
    } exp_t;

    exp_t              sb_q[$];
    int                total = 0;
    int                bad = 0;
    int                chip_cnt = 0;
    int                cyc = 0;
    int                first_valid_cyc = 0;
    int                last_valid_cyc = 0;
    bit                arm_first = 1'b0;
    logic [LFSR_W-1:0] lfsr_m = 16'h0001;

    // Monitor: one comparison per valid chip, sampled just after the active edge.
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        cyc++;
        if (o_tx_valid) begin
            chip_cnt++;
            last_valid_cyc = cyc;
            if (arm_first) begin
                first_valid_cyc = cyc;
                arm_first = 1'b0;
            end
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_chip: got tx=%0d half=%0d bit=%0d, required no valid chip",
                         o_tx, o_frame_half, o_bit_idx);
            end else begin
                e = sb_q.pop_front();
                if (o_tx !== e.tx || o_frame_half !== e.half || o_bit_idx !== e.bidx) begin
                    bad++;
                    $display("FAIL chip#%0d: got tx=%0d half=%0d bit=%0d, required tx=%0d half=%0d bit=%0d",
                             chip_cnt, o_tx, o_frame_half, o_bit_idx, e.tx, e.half, e.bidx);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic model_msg(input logic [MSG_W-1:0] msg, input logic [SF_W-1:0] sf, input bit msb);
        int   sfe;
        logic refc [0:31];
        logic b;
        exp_t e;
        sfe = (sf == 0) ? 1 : int'(sf);
        for (int bi = 0; bi < MSG_W; bi++) begin
            b = msb ? msg[MSG_W-1-bi] : msg[bi];
            for (int c = 0; c < sfe; c++) begin
                refc[c] = lfsr_m[0];
                e.tx    = lfsr_m[0];
                e.half  = 1'b0;
                e.bidx  = BI_W'(bi);
                sb_q.push_back(e);
                lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
            end
            for (int c = 0; c < sfe; c++) begin
                e.tx   = ~(refc[c] ^ b);
                e.half = 1'b1;
                e.bidx = BI_W'(bi);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic send(input logic [MSG_W-1:0] msg, input logic [SF_W-1:0] sf, input bit msb);
        int n = 0;
        @(negedge i_clk);
        i_msg       = msg;
        i_sf        = sf;
        i_msb_first = msb;
        i_msg_valid = 1'b1;
        while (!o_msg_ready && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_msg_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: o_msg_ready=0 for %0d cycles, required 1", n);
            i_msg_valid = 1'b0;
            return;
        end
        @(posedge i_clk);
        model_msg(msg, sf, msb);
        $display("msg accepted: msg=%02h sf=%0d msb_first=%0d queued=%0d", msg, sf, msb, sb_q.size());
        @(negedge i_clk);
        i_msg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!(sb_q.size() == 0 && !o_is_sending && !o_tx_valid) && n < 3000);
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: pending=%0d sending=%0d, required 0 and 0", sb_q.size(), o_is_sending);
            sb_q.delete();
        end
    endtask

    task automatic load_seed(input logic [LFSR_W-1:0] s);
        @(negedge i_clk);
        i_seed      = s;
        i_load_seed = 1'b1;
        @(negedge i_clk);
        i_load_seed = 1'b0;
        lfsr_m = (s == '0) ? 16'h0001 : s;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"}, int'(o_tx), 0);
        check({tag, "_tx_valid"}, int'(o_tx_valid), 0);
        check({tag, "_frame_half"}, int'(o_frame_half), 0);
        check({tag, "_bit_idx"}, int'(o_bit_idx), 0);
        check({tag, "_is_sending"}, int'(o_is_sending), 0);
        check({tag, "_msg_ready"}, int'(o_msg_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        i_arst_n    = 1'b0;
        i_seed      = '0;
        i_load_seed = 1'b0;
        i_sf        = 5'd4;
        i_msb_first = 1'b1;
        i_msg       = '0;
        i_msg_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_arst_n = 1'b1;
        lfsr_m   = 16'h0001;

        // Seed 1, SF=4, A5 MSB-first, with first-chip latency check.
        load_seed(16'h0001);
        c0 = chip_cnt;
        send(8'hA5, 5'd4, 1'b1);
        check("latency_edge_k", int'(o_tx_valid), 0);
        @(negedge i_clk);
        check("latency_edge_k1", int'(o_tx_valid), 0);
        @(negedge i_clk);
        check("latency_edge_k2", int'(o_tx_valid), 1);
        wait_idle();
        check("a5_chip_count", chip_cnt - c0, 64);

        // Seed 0 must behave exactly like seed 1.
        load_seed(16'h0000);
        c0 = chip_cnt;
        send(8'h3C, 5'd2, 1'b0);
        wait_idle();
        check("seed0_chip_count", chip_cnt - c0, 32);

        // Back-to-back FF then 00 at SF=3: 96 contiguous chips.
        load_seed(16'h0001);
        c0 = chip_cnt;
        arm_first = 1'b1;
        send(8'hFF, 5'd3, 1'b1);
        check("slot_full_ready_low_1", int'(o_msg_ready), 0);
        send(8'h00, 5'd3, 1'b1);
        check("slot_full_ready_low_2", int'(o_msg_ready), 0);
        wait_idle();
        check("b2b_chip_count", chip_cnt - c0, 96);
        check("b2b_contiguous_span", last_valid_cyc - first_valid_cyc + 1, 96);

        // Mid-message SF change and seed-load attempt must not disturb the active message.
        load_seed(16'h0001);
        c0 = chip_cnt;
        send(8'h5A, 5'd4, 1'b1);
        i_sf = 5'd7;
        repeat (3) @(negedge i_clk);
        i_seed      = 16'hFFFF;
        i_load_seed = 1'b1;
        @(negedge i_clk);
        i_load_seed = 1'b0;
        send(8'h81, 5'd7, 1'b0);
        wait_idle();
        check("sf_change_chip_count", chip_cnt - c0, 64 + 112);

        // SF=0 treated as 1, LSB-first 01.
        load_seed(16'h0001);
        c0 = chip_cnt;
        send(8'h01, 5'd0, 1'b0);
        wait_idle();
        check("sf0_chip_count", chip_cnt - c0, 16);

        // Reset at chip 10 with a second message pending in the slot.
        load_seed(16'h0001);
        c0 = chip_cnt;
        send(8'hC3, 5'd4, 1'b1);
        send(8'h77, 5'd5, 1'b1);
        n = 0;
        while (chip_cnt - c0 < 10 && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        check("reached_chip10", (chip_cnt - c0 >= 10) ? 1 : 0, 1);
        i_arst_n = 1'b0;
        sb_q.delete();
        lfsr_m = 16'h0001;
        @(negedge i_clk);
        check_reset_outputs("midmsg_reset");
        i_arst_n = 1'b1;
        c0 = chip_cnt;
        repeat (40) @(negedge i_clk);
        check("abort_no_chips", chip_cnt - c0, 0);
        check("abort_idle", int'(o_is_sending), 0);

        // Handshake coincident with reset is discarded.
        i_arst_n    = 1'b0;
        i_msg       = 8'hE7;
        i_sf        = 5'd2;
        i_msg_valid = 1'b1;
        @(negedge i_clk);
        i_msg_valid = 1'b0;
        i_arst_n    = 1'b1;
        c0 = chip_cnt;
        repeat (6) @(negedge i_clk);
        check("reset_hs_dropped_sending", int'(o_is_sending), 0);
        check("reset_hs_dropped_ready", int'(o_msg_ready), 1);
        check("reset_hs_dropped_chips", chip_cnt - c0, 0);

        // Core still works after the aborts; LFSR restarted from 1 by reset.
        c0 = chip_cnt;
        send(8'h96, 5'd2, 1'b1);
        wait_idle();
        check("post_reset_chip_count", chip_cnt - c0, 32);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
